// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up and MTHI/MTLO access to HI/LO.
module mult_div_unit #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_rs,
    input  logic [WIDTH-1:0] operand_rt,
    input  logic             write_hi,
    input  logic             write_lo,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    if (ITERATIONS != WIDTH) begin : g_bad_iterations
        $error("mult_div_unit: ITERATIONS must equal WIDTH");
    end

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIXUP} state_t;

    state_t               state, state_next;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     rs_q, rt_q;
    logic                 div_zero_q;
    logic                 neg_main_q;   // product / quotient must be negated
    logic                 neg_rem_q;    // remainder takes the dividend's sign
    logic [WIDTH-1:0]     mag_op;       // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0]   acc, acc_step;
    logic [CNT_W-1:0]     count;
    logic [WIDTH:0]       sum, trial;

    wire is_div    = op_q[1];
    wire is_signed = ~op_q[0];

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = ITER;
            ITER:    if (count == CNT_W'(ITERATIONS - 1)) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply keeps the multiplier in the low half and shifts the running sum in from the top;
    // divide keeps {partial remainder, quotient} and shifts left one bit per step.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_op} : '0);
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_op};
        if (is_div) begin
            acc_step = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {sum, acc[WIDTH-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            op_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            div_zero_q <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            mag_op     <= '0;
            acc        <= '0;
            count      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_hi) hi <= write_data;
                    if (write_lo) lo <= write_data;
                    if (start) begin
                        op_q       <= op;
                        rs_q       <= operand_rs;
                        rt_q       <= operand_rt;
                        div_zero_q <= op[1] && (operand_rt == '0);
                        busy       <= 1'b1;
                    end
                end
                PREP: begin
                    mag_op     <= is_div ? magnitude(rt_q, is_signed) : magnitude(rs_q, is_signed);
                    acc        <= {{WIDTH{1'b0}},
                                   is_div ? magnitude(rs_q, is_signed) : magnitude(rt_q, is_signed)};
                    neg_main_q <= is_signed && (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
                    neg_rem_q  <= is_signed && rs_q[WIDTH-1];
                    count      <= '0;
                end
                ITER: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                end
                FIXUP: begin
                    if (div_zero_q) begin
                        hi <= rs_q;
                        lo <= '1;
                    end else if (is_div) begin
                        hi <= neg_rem_q  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        lo <= neg_main_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
                    end else begin
                        {hi, lo} <= neg_main_q ? -acc : acc;
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic/timing model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_mult_div_unit;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
    localparam int LATENCY = 34;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_rs = '0, operand_rt = '0;
    logic        write_hi = 1'b0, write_lo = 1'b0;
    logic [31:0] write_data = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int compared   = 0;
    int mismatched = 0;
    bit cmp_en     = 1'b0;

    mult_div_unit #(.WIDTH(32), .ITERATIONS(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_rs(operand_rs), .operand_rt(operand_rt),
        .write_hi(write_hi), .write_lo(write_lo), .write_data(write_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} of one operation, straight from the arithmetic rules.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            MULT:  res = sa * sb;
            MULTU: res = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    // Model state: result pending for a fixed number of edges after acceptance.
    logic [31:0] exp_hi = '0, exp_lo = '0, pend_hi = '0, pend_lo = '0;
    logic        exp_busy = 1'b0, exp_done = 1'b0;
    int          remaining = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_hi <= '0; exp_lo <= '0; exp_busy <= 1'b0; exp_done <= 1'b0; remaining <= 0;
        end else begin
            exp_done <= 1'b0;
            if (remaining == 0) begin
                if (write_hi) exp_hi <= write_data;
                if (write_lo) exp_lo <= write_data;
                if (start) begin
                    {pend_hi, pend_lo} <= model(op, operand_rs, operand_rt);
                    remaining <= LATENCY;
                    exp_busy  <= 1'b1;
                end
            end else begin
                remaining <= remaining - 1;
                if (remaining == 1) begin
                    exp_hi   <= pend_hi;
                    exp_lo   <= pend_lo;
                    exp_done <= 1'b1;
                    exp_busy <= 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("done", {31'b0, done}, {31'b0, exp_done});
            check("hi", hi, exp_hi);
            check("lo", lo, exp_lo);
        end
    end

    // Called at a negedge; leaves at the negedge after the accepting edge with operands scrambled.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operand_rs = a; operand_rt = b;
        @(negedge clock);
        start = 1'b0; op = ~o; operand_rs = ~a; operand_rt = ~b;
        write_hi = 1'b0; write_lo = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (busy) cyc++;
            @(negedge clock);
        end
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want_hi, input logic [31:0] want_lo);
        int cyc;
        issue(o, a, b);
        wait_done(cyc);
        check({name, "_busy_cycles"}, cyc, LATENCY);
        check({name, "_hi"}, hi, want_hi);
        check({name, "_lo"}, lo, want_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, dones;
        #1 reset = 1'b1;
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        cmp_en = 1'b1;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;

        @(negedge clock);
        run("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clock);
        run("mult_neg", MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        @(negedge clock);
        run("div_neg", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clock);
        run("divu_zero", DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        @(negedge clock);
        run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        // Back-to-back: start issued in the very cycle done is high.
        run("div_b2b", DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run("mult_min", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        @(negedge clock);
        run("div_zero_s", DIV, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MTHI in idle, then writes and starts during busy must be ignored.
        @(negedge clock);
        write_hi = 1'b1; write_data = 32'h1234_5678;
        @(negedge clock);
        write_hi = 1'b0;
        check("mthi", hi, 32'h1234_5678);
        issue(MULTU, 32'd3, 32'd5);
        repeat (5) @(negedge clock);
        start = 1'b1; op = DIVU; operand_rs = 32'd100; operand_rt = 32'd7;
        write_lo = 1'b1; write_data = 32'hDEAD_BEEF;
        @(negedge clock);
        start = 1'b0; write_lo = 1'b0;
        check("hi_held", hi, 32'h1234_5678);
        wait_done(cyc);
        check("mul15_hi", hi, 32'h0);
        check("mul15_lo", lo, 32'h0000_000F);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("no_extra_done", dones, 0);

        // Write and start in the same idle cycle: write lands, result overwrites later.
        write_lo = 1'b1; write_data = 32'h0000_AAAA;
        issue(MULTU, 32'd2, 32'd3);
        check("mtlo_with_start", lo, 32'h0000_AAAA);
        wait_done(cyc);
        check("mul6_lo", lo, 32'h0000_0006);

        // Reset in the middle of an iteration.
        @(negedge clock);
        issue(DIVU, 32'd100, 32'd7);
        repeat (11) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("no_done_after_reset", dones, 0);
        run("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
